// File: rtl/peridot_csr_spi_slave_pkg.sv
// Shared definitions for the PERIDOT CSR SPI slave.
// Provides the register offsets, the CSR bit positions, the SPI mode bit
// meanings, the shift-engine state codes and a byte bit-reversal helper.
package peridot_csr_spi_slave_pkg;

  // Register offsets (avs_address)
  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_CONFIG = 1'b1;

  // reg00 bit positions
  localparam int IRQENA_BIT = 15;
  localparam int SEL_BIT    = 11;  // read: sel
  localparam int TXWR_BIT   = 11;  // write: load txdata
  localparam int OVR_BIT    = 10;
  localparam int RXV_BIT    = 9;
  localparam int TXE_BIT    = 8;

  // reg01 bit positions
  localparam int BITRVS_BIT = 15;
  localparam int MODE_HI    = 13;
  localparam int MODE_LO    = 12;
  localparam int ENA_BIT    = 0;

  // SPI mode bits
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

endpackage

// File: rtl/peridot_spi_slave_sync.sv
// Two-flop synchronizer plus a history flop for one asynchronous SPI pin.
// Ports:
//   clock_sig, reset_sig : module clock, asynchronous active-high reset
//   pin                  : asynchronous input pin
//   level                : synchronized level
//   rise, fall           : one-cycle pulses on a synchronized level change
module peridot_spi_slave_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock_sig,
  input  logic reset_sig,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour (a true shift chain).
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      meta <= pin;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/peridot_csr_spi_slave.sv
// SPI slave with an Avalon-MM CSR interface, one byte at a time.
// Ports:
//   clock_sig, reset_sig  : module clock, asynchronous active-high reset
//   avs_address/read/write/writedata/readdata : CSR slave (2 registers,
//                           read has 1 wait cycle, write has none)
//   ins_irq               : level interrupt, irqena & (rxvalid | overrun)
//   spi_ss_n, spi_sclk, spi_mosi : SPI inputs, oversampled in clock_sig
//   spi_miso, spi_miso_oe : SPI data out and its output enable
module peridot_csr_spi_slave
  import peridot_csr_spi_slave_pkg::*;
#(
  parameter logic       DEFAULT_REG_BITRVS = 1'b0,
  parameter logic [1:0] DEFAULT_REG_MODE   = 2'd0,
  parameter logic [7:0] DUMMY_DATA         = 8'hFF
) (
  input  logic        clock_sig,
  input  logic        reset_sig,
  input  logic        avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        ins_irq,
  input  logic        spi_ss_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  // Pin synchronizers
  logic ss_n_sync, ss_n_rise_unused, ss_n_fall_unused;
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  peridot_spi_slave_sync #(.RST_VAL(1'b1)) u_sync_ss_n (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .pin       (spi_ss_n),
    .level     (ss_n_sync),
    .rise      (ss_n_rise_unused),
    .fall      (ss_n_fall_unused)
  );

  peridot_spi_slave_sync #(.RST_VAL(DEFAULT_REG_MODE[CPOL_BIT])) u_sync_sclk (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .pin       (spi_sclk),
    .level     (sclk_sync_unused),
    .rise      (sclk_rise),
    .fall      (sclk_fall)
  );

  peridot_spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .pin       (spi_mosi),
    .level     (mosi_sync),
    .rise      (mosi_rise_unused),
    .fall      (mosi_fall_unused)
  );

  // CSR state
  logic       irqena, enable, bitrvs;
  logic [1:0] mode;
  logic       rxvalid, overrun, txfull;
  logic [7:0] txdata, rxdata;

  // Shift engine state
  state_t     state;
  logic [2:0] bitcount;
  logic [6:0] rxshift;
  logic [7:0] txshift;

  logic cpol, cpha, sel;
  logic lead_edge, trail_edge, sample_edge, drive_edge;
  logic start, active, done, reload;
  logic [7:0] load_byte, load_val, rx_byte;
  logic wr_status, wr_config;
  logic [31:0] status_word, config_word;
  logic unused_wd;

  assign cpol = mode[CPOL_BIT];
  assign cpha = mode[CPHA_BIT];
  assign sel  = enable & ~ss_n_sync;

  // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign drive_edge  = cpha ? lead_edge  : trail_edge;

  assign start  = (state == ST_IDLE) && sel;
  assign active = (state == ST_SHIFT) && sel;
  assign done   = active && sample_edge && (bitcount == 3'd7);
  assign reload = start || done;

  // The shifter is MSB-first; bit order is flipped at the register boundary.
  assign load_byte = txfull ? txdata : DUMMY_DATA;
  assign load_val  = bitrvs ? bit_rev8(load_byte) : load_byte;
  assign rx_byte   = {rxshift, mosi_sync};

  assign wr_status = avs_write && (avs_address == REG_STATUS);
  assign wr_config = avs_write && (avs_address == REG_CONFIG);

  assign status_word = {16'h0, irqena, 3'b000, sel, overrun, rxvalid, ~txfull, rxdata};
  assign config_word = {16'h0, bitrvs, 1'b0, mode, 11'h000, enable};

  assign unused_wd = &{1'b0, avs_writedata[31:16], avs_writedata[14], avs_writedata[8]};

  // Shift engine FSM with registered MISO / MISO enable
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state       <= ST_IDLE;
      bitcount    <= 3'd0;
      rxshift     <= 7'd0;
      txshift     <= 8'd0;
      spi_miso    <= 1'b1;
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= sel;
      case (state)
        ST_IDLE: begin
          bitcount <= 3'd0;
          if (sel) begin
            txshift <= load_val;
            if (!cpha) spi_miso <= load_val[7];
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!sel) begin
            // Partial byte is dropped; rxshift is overwritten by the next byte.
            state    <= ST_IDLE;
            bitcount <= 3'd0;
          end else if (sample_edge) begin
            rxshift  <= rx_byte[6:0];
            bitcount <= bitcount + 3'd1;
            if (bitcount == 3'd7) begin
              txshift <= load_val;
              if (!cpha) spi_miso <= load_val[7];
            end
          end else if (drive_edge) begin
            if (cpha) begin
              spi_miso <= txshift[7];
              txshift  <= {txshift[6:0], 1'b0};
            end else if (bitcount != 3'd0) begin
              // bitcount==0 here means the byte just completed and the reload
              // already put the new bit7 on MISO, so this edge is skipped.
              txshift  <= {txshift[6:0], 1'b0};
              spi_miso <= txshift[6];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // CSR registers; hardware set of rxvalid/overrun wins over a CPU clear,
  // and a txdata write wins over the reload that empties the slot.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      avs_readdata <= 32'h0;
      irqena       <= 1'b0;
      enable       <= 1'b0;
      bitrvs       <= DEFAULT_REG_BITRVS;
      mode         <= DEFAULT_REG_MODE;
      rxvalid      <= 1'b0;
      overrun      <= 1'b0;
      txfull       <= 1'b0;
      // NOTE: the data bytes are ordinary flops, not a memory, so they are
      // reset too and the first readback of rxdata is a defined zero.
      txdata       <= 8'h00;
      rxdata       <= 8'h00;
      ins_irq      <= 1'b0;
    end else begin
      if (avs_read) begin
        avs_readdata <= (avs_address == REG_CONFIG) ? config_word : status_word;
      end

      if (wr_status) irqena <= avs_writedata[IRQENA_BIT];

      if (wr_config && !sel) begin
        bitrvs <= avs_writedata[BITRVS_BIT];
        mode   <= avs_writedata[MODE_HI:MODE_LO];
        enable <= avs_writedata[ENA_BIT];
      end

      if (wr_status && avs_writedata[TXWR_BIT]) begin
        txdata <= avs_writedata[7:0];
        txfull <= 1'b1;
      end else if (reload) begin
        txfull <= 1'b0;
      end

      if (done) rxdata <= bitrvs ? bit_rev8(rx_byte) : rx_byte;

      if (done) rxvalid <= 1'b1;
      else if (wr_status && avs_writedata[RXV_BIT]) rxvalid <= 1'b0;

      if (done && rxvalid) overrun <= 1'b1;
      else if (wr_status && avs_writedata[OVR_BIT]) overrun <= 1'b0;

      ins_irq <= irqena & (rxvalid | overrun);
    end
  end

endmodule

// File: tb/tb_peridot_csr_spi_slave.sv
module tb_peridot_csr_spi_slave;

  localparam int PH = 8;

  logic        clock_sig, reset_sig;
  logic        avs_address, avs_read, avs_write;
  logic [31:0] avs_readdata, avs_writedata;
  logic        ins_irq;
  logic        spi_ss_n, spi_sclk, spi_mosi, spi_miso, spi_miso_oe;

  int total = 0;
  int bad   = 0;

  peridot_csr_spi_slave dut (
    .clock_sig     (clock_sig),
    .reset_sig     (reset_sig),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .ins_irq       (ins_irq),
    .spi_ss_n      (spi_ss_n),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe)
  );

  initial clock_sig = 1'b0;
  always #5 clock_sig = ~clock_sig;

  // Behavioural model of the programmer-visible state
  logic       m_irqena, m_enable, m_bitrvs;
  logic [1:0] m_mode;
  logic       m_rxv, m_ovr, m_txfull;
  logic [7:0] m_txdata, m_rxdata, m_loaded;
  logic       in_session;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  function automatic logic [31:0] exp_status();
    logic s;
    s = in_session & m_enable;
    return {16'h0, m_irqena, 3'b000, s, m_ovr, m_rxv, ~m_txfull, m_rxdata};
  endfunction

  function automatic logic [31:0] exp_config();
    return {16'h0, m_bitrvs, 1'b0, m_mode, 11'h000, m_enable};
  endfunction

  function automatic logic exp_irq();
    return m_irqena & (m_rxv | m_ovr);
  endfunction

  task automatic model_defaults();
    m_irqena = 0; m_enable = 0; m_bitrvs = 0; m_mode = 2'd0;
    m_rxv = 0; m_ovr = 0; m_txfull = 0; m_txdata = 8'h00; m_rxdata = 8'h00;
    m_loaded = 8'hFF; in_session = 0;
  endtask

  // The slave takes its next outgoing byte: pending TX byte or dummy 0xFF.
  task automatic model_reload();
    logic [7:0] b;
    b = m_txfull ? m_txdata : 8'hFF;
    m_loaded = m_bitrvs ? rev8(b) : b;
    m_txfull = 0;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clock_sig);
    avs_write = 1'b0;
    if (a == 1'b0) begin
      m_irqena = d[15];
      if (d[11]) begin m_txfull = 1; m_txdata = d[7:0]; end
      if (d[10]) m_ovr = 0;
      if (d[9])  m_rxv = 0;
    end else if (!(in_session && m_enable)) begin
      m_bitrvs = d[15]; m_mode = d[13:12]; m_enable = d[0];
    end
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    repeat (2) @(negedge clock_sig);
    d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic set_idle_clock();
    spi_sclk = m_mode[1];
    repeat (4) @(negedge clock_sig);
  endtask

  task automatic ss_begin();
    spi_ss_n = 1'b0; in_session = 1;
    model_reload();
    repeat (PH) @(negedge clock_sig);
  endtask

  task automatic ss_end();
    repeat (PH) @(negedge clock_sig);
    spi_ss_n = 1'b1; in_session = 0;
    repeat (PH) @(negedge clock_sig);
  endtask

  // Master side: shift n bits MSB-first, sampling MISO at the sample edge.
  task automatic shift_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    logic cpol, cpha;
    cpol = m_mode[1]; cpha = m_mode[0];
    mi = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (!cpha) begin
        spi_mosi = mo[7 - k];
        repeat (PH) @(negedge clock_sig);
        mi[7 - k] = spi_miso;
        spi_sclk = ~cpol;
        repeat (PH) @(negedge clock_sig);
        spi_sclk = cpol;
      end else begin
        spi_sclk = ~cpol;
        spi_mosi = mo[7 - k];
        repeat (PH) @(negedge clock_sig);
        mi[7 - k] = spi_miso;
        spi_sclk = cpol;
        repeat (PH) @(negedge clock_sig);
      end
    end
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input string name);
    logic [7:0] mi;
    shift_bits(mo, 8, mi);
    total++;
    if (mi !== m_loaded) begin
      bad++;
      $display("FAIL %s miso: got %h want %h", name, mi, m_loaded);
    end
    if (m_rxv) m_ovr = 1;
    m_rxv = 1;
    m_rxdata = m_bitrvs ? rev8(mo) : mo;
    model_reload();
  endtask

  task automatic cmp_status(input string name);
    logic [31:0] d;
    rd(1'b0, d);
    total++;
    if (d !== exp_status()) begin
      bad++;
      $display("FAIL %s reg00: got %h want %h", name, d, exp_status());
    end
  endtask

  task automatic cmp_config(input string name);
    logic [31:0] d;
    rd(1'b1, d);
    total++;
    if (d !== exp_config()) begin
      bad++;
      $display("FAIL %s reg01: got %h want %h", name, d, exp_config());
    end
  endtask

  task automatic cmp_irq(input string name);
    total++;
    if (ins_irq !== exp_irq()) begin
      bad++;
      $display("FAIL %s irq: got %b want %b", name, ins_irq, exp_irq());
    end
  endtask

  task automatic test_reset();
    reset_sig = 1'b1;
    avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
    spi_ss_n = 1; spi_sclk = 0; spi_mosi = 0;
    model_defaults();
    repeat (3) @(negedge clock_sig);
    reset_sig = 1'b0;
    total += 3;
    if (spi_miso !== 1'b1)    begin bad++; $display("FAIL reset miso: got %b want 1", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset oe: got %b want 0", spi_miso_oe); end
    if (ins_irq !== 1'b0)     begin bad++; $display("FAIL reset irq: got %b want 0", ins_irq); end
    cmp_status("reset");
    cmp_config("reset");
  endtask

  task automatic test_mode0();
    wr(1'b1, 32'h0000_0001);
    set_idle_clock();
    wr(1'b0, 32'h0000_88A5);
    ss_begin();
    total++;
    if (spi_miso_oe !== 1'b1) begin bad++; $display("FAIL mode0 oe: got %b want 1", spi_miso_oe); end
    xfer_byte(8'h3C, "mode0");
    ss_end();
    cmp_status("mode0");
    cmp_irq("mode0");
  endtask

  task automatic test_mode3_bitrvs();
    wr(1'b0, 32'h0000_0200);
    wr(1'b1, 32'h0000_B001);
    set_idle_clock();
    ss_begin();
    xfer_byte(8'h01, "mode3_rvs");
    ss_end();
    cmp_status("mode3_rvs");
  endtask

  task automatic test_back_to_back();
    wr(1'b1, 32'h0000_0001);
    set_idle_clock();
    wr(1'b0, 32'h0000_8200);
    ss_begin();
    xfer_byte(8'h11, "b2b_1");
    xfer_byte(8'h22, "b2b_2");
    ss_end();
    cmp_status("b2b_ovr");
    cmp_irq("b2b_ovr");
    wr(1'b0, 32'h0000_8600);
    cmp_status("b2b_clr");
    cmp_irq("b2b_clr");
  endtask

  task automatic test_partial();
    logic [7:0] mi;
    ss_begin();
    shift_bits(8'h5A, 5, mi);
    repeat (PH) @(negedge clock_sig);
    spi_ss_n = 1'b1; in_session = 0;
    repeat (3) @(negedge clock_sig);
    total++;
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL partial oe: got %b want 0", spi_miso_oe); end
    repeat (PH) @(negedge clock_sig);
    cmp_status("partial");
    ss_begin();
    xfer_byte(8'h7E, "after_partial");
    ss_end();
    cmp_status("after_partial");
  endtask

  // TX write lands on the same clock as the session-start reload.
  task automatic test_simultaneous();
    logic [7:0] val;
    val = 8'h5C;
    wr(1'b1, 32'h0000_1001);
    set_idle_clock();
    spi_ss_n = 1'b0; in_session = 1;
    repeat (2) @(negedge clock_sig);
    avs_address = 1'b0; avs_writedata = {24'h0000_08, val}; avs_write = 1'b1;
    @(negedge clock_sig);
    avs_write = 1'b0;
    model_reload();
    m_irqena = 0; m_txfull = 1; m_txdata = val;
    cmp_status("simul_txfull");
    repeat (PH) @(negedge clock_sig);
    xfer_byte(8'hC3, "simul_1");
    cmp_status("simul_txempty");
    xfer_byte(8'h96, "simul_2");
    ss_end();
    cmp_status("simul_end");
  endtask

  task automatic test_lock_and_reset();
    logic [7:0] mi;
    wr(1'b0, 32'h0000_8000);
    ss_begin();
    cmp_irq("pre_reset");
    wr(1'b1, 32'h0000_3001);
    cmp_config("locked");
    shift_bits(8'hA0, 3, mi);
    #2 reset_sig = 1'b1;
    #1;
    total += 3;
    if (spi_miso !== 1'b1)    begin bad++; $display("FAIL midreset miso: got %b want 1", spi_miso); end
    if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL midreset oe: got %b want 0", spi_miso_oe); end
    if (ins_irq !== 1'b0)     begin bad++; $display("FAIL midreset irq: got %b want 0", ins_irq); end
    @(negedge clock_sig);
    reset_sig = 1'b0;
    spi_ss_n = 1'b1; spi_sclk = 1'b0;
    model_defaults();
    repeat (4) @(negedge clock_sig);
    cmp_status("after_reset");
    cmp_config("after_reset");
  endtask

  task automatic test_random();
    logic [31:0] cfg, wd;
    int nb;
    for (int s = 0; s < 6; s++) begin
      cfg = ($urandom & 32'hFFFF_4FFE) | (32'($urandom_range(0, 1)) << 15)
          | (32'($urandom_range(0, 3)) << 12) | 32'h1;
      wr(1'b1, cfg);
      set_idle_clock();
      wd = $urandom;
      wr(1'b0, wd);
      ss_begin();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) xfer_byte(8'($urandom), "random");
      ss_end();
      cmp_status("random");
      cmp_config("random");
      cmp_irq("random");
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_bitrvs();
    test_back_to_back();
    test_partial();
    test_simultaneous();
    test_lock_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
